// File: rtl/somador_acumulador.sv
// -----------------------------------------------------------------------------
// somador_acumulador
//   Signed adder / subtractor / accumulator. The result and its Z/N/P/V flags
//   sit in one output register, with a valid/ready handshake on each side.
//
// Parameters
//   WIDTH      operand/result width, two's complement (2..32), default 8
//
// Optional build macro
//   SOMADOR_SAT_EN  when defined, an overflowing result clamps to the nearest
//                   representable extreme instead of wrapping. V is still set.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   A, B           signed operands
//   op             00 ADD A+B, 01 SUB A-B, 10 ACC acc+A, 11 CLR
//   in_valid       op/operands valid         in_ready   block can accept
//   S              registered signed result
//   Z/N/P/V        zero / negative / even / signed overflow of S
//   out_valid      S/flags hold an unconsumed result
//   out_ready      consumer takes the result
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid && !ready.
// in_ready = !out_valid || out_ready, so a new op may be accepted on the
// same edge that the current result is consumed. In that case the new
// result replaces the old one and out_valid stays high.
//
// The only state is r_out_valid (EMPTY=0 / FULL=1), visible on out_valid.
// -----------------------------------------------------------------------------
module somador_acumulador #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S,
  output logic             Z,
  output logic             N,
  output logic             P,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_acc;
  logic             r_z;
  logic             r_n;
  logic             r_p;
  logic             r_v;
  logic             r_out_valid;

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_acc_ext;
  logic [WIDTH:0]   w_raw;
  logic             w_ovf;
  logic [WIDTH-1:0] w_s_next;
  logic             w_accept;

  // One guard bit lets the overflow test compare the two top bits of the sum.
  assign w_a_ext   = {A[WIDTH-1], A};
  assign w_b_ext   = {B[WIDTH-1], B};
  assign w_acc_ext = {r_acc[WIDTH-1], r_acc};

  always_comb begin
    w_raw = '0;
    case (op)
      OP_ADD:  w_raw = w_a_ext + w_b_ext;
      OP_SUB:  w_raw = w_a_ext + ~w_b_ext + {{WIDTH{1'b0}}, 1'b1};
      OP_ACC:  w_raw = w_acc_ext + w_a_ext;
      default: w_raw = '0;
    endcase
  end

  // CLR produces raw = 0, so it can never flag overflow.
  assign w_ovf = (op != OP_CLR) && (w_raw[WIDTH] != w_raw[WIDTH-1]);

`ifdef SOMADOR_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // The guard bit w_raw[WIDTH] carries the true sign of the unclamped sum.
  always_comb begin
    w_s_next = w_raw[WIDTH-1:0];
    if (w_ovf) begin
      w_s_next = w_raw[WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign w_s_next = w_raw[WIDTH-1:0];
`endif

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Flags are registered together with S. That way they read 0 after reset,
  // even though S=0 there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_acc       <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_p         <= 1'b0;
      r_v         <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_s         <= w_s_next;
      r_acc       <= w_s_next;
      r_z         <= (w_s_next == '0);
      r_n         <= w_s_next[WIDTH-1];
      r_p         <= ~w_s_next[0];
      r_v         <= w_ovf;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign S         = r_s;
  assign Z         = r_z;
  assign N         = r_n;
  assign P         = r_p;
  assign V         = r_v;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_somador_acumulador.sv
module tb_somador_acumulador;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic         z;
  logic         n;
  logic         p;
  logic         v;
  logic         out_valid;
  logic         out_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  somador_acumulador #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (s),
    .Z         (z),
    .N         (n),
    .P         (p),
    .V         (v),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // check task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] e_s,
                           input logic e_z, input logic e_n, input logic e_p, input logic e_v);
    check({tag, ".S"}, 32'(s), 32'(e_s));
    check({tag, ".Z"}, 32'(z), 32'(e_z));
    check({tag, ".N"}, 32'(n), 32'(e_n));
    check({tag, ".P"}, 32'(p), 32'(e_p));
    check({tag, ".V"}, 32'(v), 32'(e_v));
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Driver: present one op at the falling edge, wait (bounded) for acceptance,
  // then leave the sample point 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b);
    int waited;
    @(negedge clk);
    op       = t_op;
    a        = t_a;
    b        = t_b;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send.in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [W-1:0] e3_s, e4_s;
  logic         e3_n, e3_p, e4_n, e4_p;

  logic [1:0]   v6_op[3];
  logic [W-1:0] v6_a[3];
  logic [W-1:0] v6_b[3];

  initial begin
`ifdef SOMADOR_SAT_EN
    e3_s = 8'd127; e3_n = 1'b0; e3_p = 1'b0;
    e4_s = 8'd127; e4_n = 1'b0; e4_p = 1'b0;
`else
    e3_s = 8'hC8;  e3_n = 1'b1; e3_p = 1'b1;
    e4_s = 8'h80;  e4_n = 1'b1; e4_p = 1'b1;
`endif
    v6_op[0] = 2'b10; v6_a[0] = 8'd10; v6_b[0] = 8'd0;
    v6_op[1] = 2'b00; v6_a[1] = 8'd50; v6_b[1] = 8'd50;
    v6_op[2] = 2'b00; v6_a[2] = 8'd1;  v6_b[2] = 8'd1;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00;

    // 1. reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.S", 32'(s), 32'd0);
    check("rst.Z", 32'(z), 32'd0);
    check("rst.N", 32'(n), 32'd0);
    check("rst.P", 32'(p), 32'd0);
    check("rst.V", 32'(v), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. ADD
    send(2'b00, 8'd5, 8'hFB);
    check_res("add5m5", 8'd0, 1, 0, 1, 0);
    send(2'b00, 8'd3, 8'd4);
    check_res("add3p4", 8'd7, 0, 0, 0, 0);

    // 3. ADD overflow
    send(2'b00, 8'd100, 8'd100);
    check_res("add100", e3_s, 0, e3_n, e3_p, 1);

    // 4. SUB
    send(2'b01, 8'd0, 8'h80);
    check_res("sub0m128", e4_s, 0, e4_n, e4_p, 1);
    send(2'b01, 8'hFD, 8'd2);
    check_res("subm3m2", 8'hFB, 0, 1, 0, 0);

    // 5. accumulator chain and CLR
    send(2'b00, 8'd10, 8'd0);
    check_res("seed10", 8'd10, 0, 0, 1, 0);
    send(2'b10, 8'd20, 8'd77);
    check_res("acc20", 8'd30, 0, 0, 1, 0);
    send(2'b10, 8'hD8, 8'd0);
    check_res("accm40", 8'hF6, 0, 1, 1, 0);
    send(2'b11, 8'd9, 8'd9);
    check_res("clr", 8'd0, 1, 0, 1, 0);
    send(2'b10, 8'd1, 8'd0);
    check_res("acc1", 8'd1, 0, 0, 0, 0);

    // 6. back-pressure, then back-to-back stream
    send(2'b00, 8'd1, 8'd2);
    check_res("bp_first", 8'd3, 0, 0, 0, 0);
    @(negedge clk);
    out_ready = 1'b0;
    op = v6_op[0]; a = v6_a[0]; b = v6_b[0];
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.S", 32'(s), 32'd3);
      check("bp.out_valid", 32'(out_valid), 32'd1);
    end
    exp_q.push_back(8'd13);  // acc held 3 through the stall
    exp_q.push_back(8'd100);
    exp_q.push_back(8'd2);
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        op = v6_op[i]; a = v6_a[i]; b = v6_b[i];
      end
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("b2b.queue_empty", 32'd1, 32'd0);
      end else begin
        check("b2b.S", 32'(s), 32'(exp_q.pop_front()));
        check("b2b.out_valid", 32'(out_valid), 32'd1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain.out_valid", 32'(out_valid), 32'd0);
    check("drain.S_kept", 32'(s), 32'd2);
    check("drain.queue_left", 32'(exp_q.size()), 32'd0);

    // 1b. asynchronous reset while a result is pending
    send(2'b00, 8'd3, 8'd4);
    check_res("pre_rst", 8'd7, 0, 0, 0, 0);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.S", 32'(s), 32'd0);
    check("arst.Z", 32'(z), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'b10, 8'd4, 8'd0);
    check_res("acc_after_rst", 8'd4, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
